// File: rtl/cache_sram_1rw1r_if.sv
// Request/response bundle for the 1RW+1R cache line SRAM.
// The master drives requests; the slave (the SRAM) returns read data, strobes and status.
interface cache_sram_1rw1r_if #(
  parameter int DATA_WIDTH = 148,
  parameter int ADDR_WIDTH = 11,
  parameter int NUM_WMASKS = (DATA_WIDTH + 7) / 8
);
  logic                  csb0;
  logic                  web0;
  logic [NUM_WMASKS-1:0] wmask0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] din0;
  logic [DATA_WIDTH-1:0] dout0;
  logic                  dvalid0;
  logic                  csb1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] dout1;
  logic                  dvalid1;
  logic                  init_busy;
  logic                  collision;

  modport master (
    output csb0, web0, wmask0, addr0, din0, csb1, addr1,
    input  dout0, dvalid0, dout1, dvalid1, init_busy, collision
  );

  modport slave (
    input  csb0, web0, wmask0, addr0, din0, csb1, addr1,
    output dout0, dvalid0, dout1, dvalid1, init_busy, collision
  );
endinterface

// File: rtl/cache_sram_1rw1r.sv
// Behavioural 1RW+1R cache line SRAM: byte-lane writes, configurable read latency with
// valid strobes, defined write/read collision policy and a post-reset clear sweep.
module cache_sram_1rw1r #(
  parameter int DATA_WIDTH     = 148,
  parameter int ADDR_WIDTH     = 11,
  parameter int RAM_DEPTH      = 1 << ADDR_WIDTH,
  parameter int NUM_WMASKS     = (DATA_WIDTH + 7) / 8,
  parameter int READ_LATENCY   = 1,
  parameter bit BYPASS         = 1'b1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic               clock,
  input logic               reset,
  cache_sram_1rw1r_if.slave bus
);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt, w_cnt_nxt;

  logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];

  logic [DATA_WIDTH-1:0] r_p0_data [READ_LATENCY];
  logic [DATA_WIDTH-1:0] r_p1_data [READ_LATENCY];
  logic [READ_LATENCY-1:0] r_p0_vld, r_p1_vld;
  logic                  r_collision;

  logic                  w_busy, w_p0_wr, w_p0_rd, w_p1_rd, w_collide;
  logic [NUM_WMASKS-1:0] w_lane_we;
  logic [DATA_WIDTH-1:0] w_bmask, w_p0_old, w_p1_old, w_p1_data;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // NOTE: defaults first so no path through the always_comb leaves a variable unassigned (no latches).
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_CLEAR: begin
        w_cnt_nxt = r_cnt + ADDR_WIDTH'(1);
        if (r_cnt == ADDR_WIDTH'(RAM_DEPTH - 1)) w_state_nxt = ST_IDLE;
      end
      default: ;
    endcase
  end

  assign w_busy    = (r_state == ST_CLEAR);
  assign w_p0_wr   = !w_busy && !bus.csb0 && !bus.web0;
  assign w_p0_rd   = !w_busy && !bus.csb0 &&  bus.web0;
  assign w_p1_rd   = !w_busy && !bus.csb1;
  assign w_collide = w_p0_wr && w_p1_rd && (bus.addr0 == bus.addr1);
  assign w_lane_we = bus.wmask0;

  // Lane i covers bits [8i+7:8i]; the top lane is naturally clipped at DATA_WIDTH-1.
  always_comb begin
    w_bmask = '0;
    for (int b = 0; b < DATA_WIDTH; b++) w_bmask[b] = w_lane_we[b / 8];
  end

  assign w_p0_old  = r_mem[bus.addr0];
  assign w_p1_old  = r_mem[bus.addr1];
  assign w_p1_data = (BYPASS && w_collide) ? ((w_p1_old & ~w_bmask) | (bus.din0 & w_bmask))
                                           : w_p1_old;

  // NOTE: the array has no reset branch; zeroing is done one line per cycle by the clear sweep.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (w_busy)       r_mem[r_cnt]     <= '0;
      else if (w_p0_wr) r_mem[bus.addr0] <= (w_p0_old & ~w_bmask) | (bus.din0 & w_bmask);
    end
  end

  // Read pipelines: stage 0 snapshots the array; data only advances with a valid beat so dout holds.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_p0_vld    <= '0;
      r_p1_vld    <= '0;
      r_collision <= 1'b0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_p0_data[i] <= '0;
        r_p1_data[i] <= '0;
      end
    end else begin
      r_collision <= w_collide;
      r_p0_vld[0] <= w_p0_rd;
      r_p1_vld[0] <= w_p1_rd;
      if (w_p0_rd) r_p0_data[0] <= w_p0_old;
      if (w_p1_rd) r_p1_data[0] <= w_p1_data;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_p0_vld[i] <= r_p0_vld[i-1];
        r_p1_vld[i] <= r_p1_vld[i-1];
        if (r_p0_vld[i-1]) r_p0_data[i] <= r_p0_data[i-1];
        if (r_p1_vld[i-1]) r_p1_data[i] <= r_p1_data[i-1];
      end
    end
  end

  assign bus.dout0     = r_p0_data[READ_LATENCY-1];
  assign bus.dvalid0   = r_p0_vld[READ_LATENCY-1];
  assign bus.dout1     = r_p1_data[READ_LATENCY-1];
  assign bus.dvalid1   = r_p1_vld[READ_LATENCY-1];
  assign bus.init_busy = w_busy;
  assign bus.collision = r_collision;

endmodule

// File: tb/tb_cache_sram_1rw1r.sv
// Directed bench: three SRAM variants (latency 1/3/4, bypass on/off) share one stimulus stream.
module tb_cache_sram_1rw1r;
  localparam int DW = 148;
  localparam int AW = 11;
  localparam int NW = 19;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic          csb0, web0, csb1;
  logic [NW-1:0] wmask0;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] din0;

  int n_tests = 0;
  int n_fail  = 0;

  cache_sram_1rw1r_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NW)) if_a ();
  cache_sram_1rw1r_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NW)) if_b ();
  cache_sram_1rw1r_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NW)) if_c ();

  assign if_a.csb0 = csb0;  assign if_a.web0 = web0;  assign if_a.wmask0 = wmask0;
  assign if_a.addr0 = addr0; assign if_a.din0 = din0; assign if_a.csb1 = csb1; assign if_a.addr1 = addr1;
  assign if_b.csb0 = csb0;  assign if_b.web0 = web0;  assign if_b.wmask0 = wmask0;
  assign if_b.addr0 = addr0; assign if_b.din0 = din0; assign if_b.csb1 = csb1; assign if_b.addr1 = addr1;
  assign if_c.csb0 = csb0;  assign if_c.web0 = web0;  assign if_c.wmask0 = wmask0;
  assign if_c.addr0 = addr0; assign if_c.din0 = din0; assign if_c.csb1 = csb1; assign if_c.addr1 = addr1;

  cache_sram_1rw1r #(.READ_LATENCY(1), .BYPASS(1'b1)) u_a (.clock(clock), .reset(reset), .bus(if_a));
  cache_sram_1rw1r #(.READ_LATENCY(3), .BYPASS(1'b0)) u_b (.clock(clock), .reset(reset), .bus(if_b));
  cache_sram_1rw1r #(.READ_LATENCY(4), .BYPASS(1'b1)) u_c (.clock(clock), .reset(reset), .bus(if_c));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1;
    wmask0 = '0; addr0 = '0; addr1 = '0; din0 = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NW-1:0] m);
    csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
    tick();
    idle();
  endtask

  task automatic wait_sweep(output int n);
    n = 0;
    while (if_a.init_busy === 1'b1 && n < 3000) begin
      n++;
      tick();
    end
  endtask

  logic [DW-1:0] p_aa, p_55, d1, d2, d3, d6, exp_v;
  int n, seen;

  initial begin
    p_aa = {37{4'hA}}; p_55 = {37{4'h5}};
    d1 = {37{4'h1}}; d2 = {37{4'h2}}; d3 = {37{4'h3}}; d6 = {37{4'h6}};
    idle();
    reset = 1'b1;
    repeat (3) tick();
    check("rst_dout0",   if_a.dout0, '0);
    check("rst_dvalid0", DW'(if_a.dvalid0), '0);
    check("rst_coll",    DW'(if_a.collision), '0);
    check("rst_busy",    DW'(if_a.init_busy), DW'(1));
    reset = 1'b0;
    wait_sweep(n);
    check("sweep_len",    DW'(n), DW'(2048));
    check("sweep_done_c", DW'(if_c.init_busy), '0);

    // Read of the last line after the sweep
    csb1 = 1'b0; addr1 = 11'h7FF;
    tick(); idle();
    check("t1_dvalid1", DW'(if_a.dvalid1), DW'(1));
    check("t1_dout1",   if_a.dout1, '0);
    tick();
    check("t1_pulse",   DW'(if_a.dvalid1), '0);

    // Lanes 0 and 18 only
    wr(11'h005, '1, 19'h40001);
    check("t2_wr_no_dvalid", DW'(if_a.dvalid0), '0);
    csb0 = 1'b0; web0 = 1'b1; addr0 = 11'h005;
    tick(); idle();
    exp_v = '0; exp_v[147:144] = 4'hF; exp_v[7:0] = 8'hFF;
    check("t2_dout0",   if_a.dout0, exp_v);
    check("t2_dvalid0", DW'(if_a.dvalid0), DW'(1));

    // Back-to-back reads, latency 3 on u_b
    wr(11'h001, d1, '1); wr(11'h002, d2, '1); wr(11'h003, d3, '1);
    csb0 = 1'b0; web0 = 1'b1; addr0 = 11'h001;
    tick();
    check("t3_a_d1", if_a.dout0, d1);
    addr0 = 11'h002;
    tick();
    check("t3_b_early", DW'(if_b.dvalid0), '0);
    addr0 = 11'h003;
    tick(); idle();
    check("t3_b_v1", DW'(if_b.dvalid0), DW'(1));
    check("t3_b_d1", if_b.dout0, d1);
    tick();
    check("t3_b_v2", DW'(if_b.dvalid0), DW'(1));
    check("t3_b_d2", if_b.dout0, d2);
    tick();
    check("t3_b_v3", DW'(if_b.dvalid0), DW'(1));
    check("t3_b_d3", if_b.dout0, d3);
    tick();
    check("t3_b_v_off", DW'(if_b.dvalid0), '0);
    check("t3_b_hold",  if_b.dout0, d3);

    // Same-address write/read collision
    wr(11'h010, p_aa, '1);
    csb0 = 1'b0; web0 = 1'b0; addr0 = 11'h010; din0 = p_55; wmask0 = '1;
    csb1 = 1'b0; addr1 = 11'h010;
    tick(); idle();
    check("t4_a_coll",  DW'(if_a.collision), DW'(1));
    check("t4_b_coll",  DW'(if_b.collision), DW'(1));
    check("t4_a_byp",   if_a.dout1, p_55);
    check("t4_a_v",     DW'(if_a.dvalid1), DW'(1));
    tick();
    check("t4_a_coll_off", DW'(if_a.collision), '0);
    check("t4_b_coll_off", DW'(if_b.collision), '0);
    tick();
    check("t4_b_old",   if_b.dout1, p_aa);
    check("t4_b_v",     DW'(if_b.dvalid1), DW'(1));
    tick();
    check("t4_c_byp",   if_c.dout1, p_55);

    // Partial-mask bypass merges written and old lanes
    csb0 = 1'b0; web0 = 1'b0; addr0 = 11'h010; din0 = '0; wmask0 = 19'h00001;
    csb1 = 1'b0; addr1 = 11'h010;
    tick(); idle();
    exp_v = p_55; exp_v[7:0] = 8'h00;
    check("t4_a_merge", if_a.dout1, exp_v);

    // Different addresses: no collision
    csb0 = 1'b0; web0 = 1'b0; addr0 = 11'h020; din0 = p_aa; wmask0 = '1;
    csb1 = 1'b0; addr1 = 11'h021;
    tick(); idle();
    check("t4_nocoll",   DW'(if_a.collision), '0);
    check("t4_nocoll_d", if_a.dout1, '0);

    // Read snapshot ahead of a later write
    csb1 = 1'b0; addr1 = 11'h003;
    tick(); idle();
    wr(11'h003, d6, '1);
    tick();
    check("t6_b_v",   DW'(if_b.dvalid1), DW'(1));
    check("t6_b_old", if_b.dout1, d3);
    csb1 = 1'b0; addr1 = 11'h003;
    tick(); idle();
    check("t6_a_new", if_a.dout1, d6);
    tick(); tick();
    check("t6_b_new", if_b.dout1, d6);

    // Reset in the middle of the sweep restarts it
    reset = 1'b1; tick(); reset = 1'b0;
    repeat (100) tick();
    check("t5_mid_busy", DW'(if_a.init_busy), DW'(1));
    reset = 1'b1; tick(); reset = 1'b0;
    wait_sweep(n);
    check("t5_sweep_len", DW'(n), DW'(2048));
    csb1 = 1'b0; addr1 = 11'h010;
    tick(); idle();
    check("t5_cleared", if_a.dout1, '0);
    check("t5_cleared_v", DW'(if_a.dvalid1), DW'(1));

    // Reset with a latency-4 read in flight
    wr(11'h040, d1, '1);
    csb0 = 1'b0; web0 = 1'b1; addr0 = 11'h040;
    tick(); idle();
    check("t5_a_rd", if_a.dout0, d1);
    tick();
    reset = 1'b1;
    tick();
    check("t5_c_dout0", if_c.dout0, '0);
    check("t5_c_dv0",   DW'(if_c.dvalid0), '0);
    check("t5_a_dout0", if_a.dout0, '0);
    check("t5_b_dout1", if_b.dout1, '0);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (if_c.dvalid0 !== 1'b0) seen++;
    end
    check("t5_c_dropped", DW'(seen), '0);
    repeat (194) tick();

    // Requests during the sweep are dropped
    csb0 = 1'b0; web0 = 1'b0; addr0 = 11'h010; din0 = '1; wmask0 = '1;
    csb1 = 1'b0; addr1 = 11'h010;
    tick(); idle();
    check("busy_no_dv",   DW'(if_a.dvalid1), '0);
    check("busy_no_coll", DW'(if_a.collision), '0);
    wait_sweep(n);
    check("t5_rest_len", DW'(n), DW'(1847));
    csb1 = 1'b0; addr1 = 11'h010;
    tick(); idle();
    check("busy_no_wr", if_a.dout1, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_sram_1rw1r.md
Name: cache_sram_1rw1r

Overview:
Parametrised, synthesisable behavioural model of the 1RW+1R cache line SRAM used by the data and instruction caches. Port 0 is read/write and port 1 is read-only. Both ports run on a single clock.
It improves on the previous macro model in five ways: byte masks span the full line width, read latency is configurable, reads return a valid strobe, same-address write/read collisions follow a defined policy, and memory is zeroed by a state machine after reset.

Parameters:
DATA_WIDTH, 148, line width in bits (128-bit data + tag + valid).
ADDR_WIDTH, 11, address bits.
RAM_DEPTH, 1<<ADDR_WIDTH, number of lines.
NUM_WMASKS, (DATA_WIDTH+7)/8, byte lanes. Lane i covers bits [8i+7:8i], clipped at DATA_WIDTH-1, so the last lane is 4 bits wide at default.
READ_LATENCY, 1, cycles from request to data; legal range 1..4.
BYPASS, 1, 1 = a port-1 read sees the same-cycle port-0 write; 0 = it sees the old data.
CLEAR_ON_RESET, 1, 1 = zero the whole array after reset; 0 = array contents are untouched by reset.

Ports:
clock  in  1  single clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
csb0  in  1  port 0 chip select, active low.
web0  in  1  port 0 write enable, active low.
wmask0  in  NUM_WMASKS  port 0 byte-lane write mask.
addr0  in  ADDR_WIDTH  port 0 address.
din0  in  DATA_WIDTH  port 0 write data.
dout0  out  DATA_WIDTH  port 0 read data.
dvalid0  out  1  one-cycle pulse marking new dout0.
csb1  in  1  port 1 chip select, active low.
addr1  in  ADDR_WIDTH  port 1 address.
dout1  out  DATA_WIDTH  port 1 read data.
dvalid1  out  1  one-cycle pulse marking new dout1.
init_busy  out  1  high while the clear sweep runs; requests are ignored.
collision  out  1  one-cycle pulse: port-0 write and port-1 read hit the same address in the same cycle.

Behaviour:
- Reset (sampled high at a rising edge):
  - dout0, dout1, dvalid0, dvalid1 and collision all go to 0.
  - Read pipelines are flushed; in-flight reads are dropped with no dvalid.
  - State machine goes to CLEAR if CLEAR_ON_RESET=1, otherwise to IDLE.
- State machine:
  - CLEAR: init_busy=1. Each cycle writes zero to mem[cnt], then cnt++. When cnt==RAM_DEPTH-1 is written, next state is IDLE. init_busy is therefore high for exactly RAM_DEPTH cycles after reset deasserts.
  - Reset asserted mid-CLEAR restarts the sweep at cnt=0.
  - IDLE: init_busy=0 and requests are served. There is no other exit from IDLE except reset.
- Port 0 write (cycle k, csb0=0, web0=0, IDLE): at edge k, every lane i with wmask0[i]=1 takes din0's lane i; all other lanes keep their value. A write with an all-zero mask is a no-op. A write produces no dvalid0.
- Port 0 read (csb0=0, web0=1, IDLE): array is read at edge k. dout0 is updated and dvalid0=1 after edge k+READ_LATENCY-1, i.e. visible during cycle k+READ_LATENCY.
- Port 1 read (csb1=0, IDLE): same timing as port 0, driving dout1 and dvalid1.
- Output hold: dout holds its last value when there is no read; dvalid is high for exactly one cycle per read. Back-to-back reads give full throughput, one result per cycle.
- Read snapshot: a read returns the array state at its sample edge. A write at a later edge does not alter an in-flight read.
- Collision (port-0 write and port-1 read, same address, same cycle k):
  - BYPASS=1: dout1 = written lanes from din0, unwritten lanes from old data.
  - BYPASS=0: dout1 = old data.
  - In both modes collision=1 during cycle k+1 only.
- Different addresses, or reads on both ports: no interaction and no collision.
- Requests presented while init_busy=1 are dropped: no write, no dvalid, no collision.
- Address range: addresses are fully decoded; there is no out-of-range case.

Test Plan:
1. Reset with CLEAR_ON_RESET=1, then hold csb0=csb1=1 → init_busy high for exactly 2048 cycles. A subsequent port-1 read of address 0x7FF returns 0 with a single dvalid1 pulse.
2. Write addr0=0x005, din0=all-ones, wmask0 with only lane 0 and lane 18 set; then read port 0 → dout0 = 0xF followed by 0x00…00FF (bits 147:144 set and bits 7:0 set, all else 0).
3. With READ_LATENCY=3, issue port-0 reads of addresses 1,2,3 on consecutive cycles → dvalid0 is high in cycles k+3, k+4 and k+5 with the matching data, and dout0 holds the last value afterwards.
4. Address 0x10 holds 0xAA pattern. In the same cycle, port 0 writes all lanes with 0x55 and port 1 reads 0x10:
   - BYPASS=1 → dout1 returns the 0x55 pattern.
   - BYPASS=0 → dout1 returns the 0xAA pattern.
   - Both modes → collision=1 for exactly one cycle.
5. Assert reset at cnt=100 of the sweep, and separately with a READ_LATENCY=4 read in flight → init_busy restarts a full 2048-cycle sweep, the in-flight dvalid never appears, and all outputs are 0.
6. Issue a port-1 read at edge k, then a write to the same address at edge k+1 → dout1 returns the pre-write data; a later read returns the new data.
